skid_fifo_axis: RTL and testbench
=================================

// Module: skid_fifo_axis
//
// PURPOSE
//   Parametrised successor to the 2-entry 8-bit skid buffer.
//   Valid/ready/last stream buffer with configurable data width and depth N.
//   Decouples an upstream source (m_* side) from a downstream sink (s_* side).
//   Absorbs sink back-pressure without dropping words.
//   Adds an occupancy output and an optional stored-packet counter.
//   Sits on byte/word stream paths between producer and consumer blocks.
//
// PARAMETERS
//   DATA_W   8   data bus width in bits, >= 1
//   DEPTH    4   storage entries; power of 2, >= 2
//   LVL_W    $clog2(DEPTH)+1   localparam; width of level/packet counters
//
// PORTS
//   clk        in   1         clock; rising edge
//   reset      in   1         asynchronous, active-low reset
//   m_data     in   DATA_W    upstream data
//   m_valid    in   1         upstream word valid
//   m_last     in   1         upstream word is last of packet
//   m_ready    out  1         buffer can accept a word this cycle
//   s_data     out  DATA_W    downstream data (head entry)
//   s_valid    out  1         head entry valid
//   s_last     out  1         head entry is last of packet
//   s_ready    in   1         downstream accepts head this cycle
//   level      out  LVL_W     stored entry count, 0..DEPTH
//   pkt_cnt    out  LVL_W     only with SKID_FIFO_PKTCNT_EN: stored complete packets
//
// BEHAVIOUR
//   - Reset (reset=0, asynchronous): pointers=0, level=0, m_ready=0,
//     s_valid=0, s_data=0, s_last=0, pkt_cnt=0.
//   - Reset flushes every stored entry.
//   - Reset release: m_ready is a register. It rises on the first rising clk edge
//     after reset=1, then equals (level != DEPTH) registered, as follows:
//     m_ready_next = !(level_next == DEPTH).
//   - push = m_valid & m_ready. pop = s_valid & s_ready.
//     Both are evaluated on the same edge.
//   - Storage: DEPTH x (DATA_W+1) register array. Entries carry {last,data}.
//   - Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
//   - Level: level += push - pop.
//   - Output: first-word-fall-through.
//     s_valid = (level != 0). s_{data,last} = mem[rd_ptr].
//     s_data and s_last read 0 when s_valid=0.
//   - Latency: a word pushed at edge k is visible on s_* after edge k.
//     That is 1 cycle; there is no combinational m->s bypass.
//   - Throughput: 1 word/cycle sustained when s_ready=1.
//     m_ready stays 1 with no bubbles.
//   - Empty (level=0): pop is impossible. push alone gives level=1.
//   - Full (level=DEPTH): m_ready=0, so push is impossible.
//     A pop makes m_ready=1 on the next cycle.
//   - Simultaneous push and pop, 0<level<DEPTH: level unchanged; both pointers advance.
//   - Ordering: strict FIFO. m_last travels with its word unchanged.
//   - Source holding m_valid=1 with m_ready=0: no state change.
//   - Sink holding s_valid with s_ready=0: s_data and s_last held stable.
//   - Reset asserted mid-packet: outputs clear immediately, without waiting for clk.
//     Pre-reset entries never appear at s_*.
//
// CONFIGURATION
//   SKID_FIFO_PKTCNT_EN defined:
//     - The pkt_cnt port exists.
//     - pkt_cnt += (push & m_last) - (pop & s_last). Range 0..DEPTH; reset 0.
//   SKID_FIFO_PKTCNT_EN undefined:
//     - The pkt_cnt port is absent. No counter logic is generated.
//   All other behaviour is identical in both builds.
//
// TESTING  (DATA_W=8, DEPTH=4 unless noted)
//   1 Reset: reset=0 with m_valid=1, m_data=FF
//     -> s_valid=0, s_data=00, s_last=0, m_ready=0, level=0.
//     Release reset -> m_ready=1 after 1st edge.
//   2 Stream: s_ready=1; send 11,22,33,44 (last on 44) on consecutive cycles
//     -> s_data 11,22,33,44, each 1 cycle later.
//     -> s_last=1 only with 44; level<=1; m_ready stays 1.
//   3 Fill: s_ready=0; offer AA,BB,CC,DD,EE
//     -> AA..DD accepted; level=4; m_ready=0; EE held upstream.
//     Then s_ready=1 -> output AA,BB,CC,DD,EE in order; level returns to 0.
//   4 Stall stability: s_ready=0 for 2 cycles with head=CC
//     -> s_data=CC and s_valid=1 stable. Restore s_ready -> CC popped once, no duplicate.
//   5 Concurrent: at level=2, push and pop every cycle for 6 cycles
//     -> level stays 2; pointers wrap past 3->0; order preserved.
//   6 Reset mid-packet: 3 entries stored; pulse reset=0 for half a cycle
//     -> s_valid=0 immediately; level=0; no old entry ever emitted.
//     With SKID_FIFO_PKTCNT_EN: prior pkt_cnt=1 clears to 0.

Source files
------------

// File: rtl/skid_fifo_axis.sv
// Valid/ready/last FWFT buffer, DEPTH x {last,data}; optional stored-packet counter under SKID_FIFO_PKTCNT_EN.
// Latency: 1 cycle m->s with no combinational bypass; sustains 1 word/cycle.
// Backpressure: registered m_ready drops when full; s_data/s_last hold while s_ready=0.
module skid_fifo_axis #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] m_data,
  input  logic              m_valid,
  input  logic              m_last,
  output logic              m_ready,
  output logic [DATA_W-1:0] s_data,
  output logic              s_valid,
  output logic              s_last,
  input  logic              s_ready,
`ifdef SKID_FIFO_PKTCNT_EN
  output logic [LVL_W-1:0]  level,
  output logic [LVL_W-1:0]  pkt_cnt
`else
  output logic [LVL_W-1:0]  level
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level_q;
  logic [LVL_W-1:0]   level_next;
  logic               m_ready_q;
  logic               push;
  logic               pop;
  logic [DATA_W:0]    head;

  assign push    = m_valid & m_ready_q;
  assign s_valid = (level_q != '0);
  assign pop     = s_valid & s_ready;
  assign head    = mem[rd_ptr];

  // Gate the head entry so stale storage never shows while empty.
  assign s_data  = s_valid ? head[DATA_W-1:0] : '0;
  assign s_last  = s_valid & head[DATA_W];
  assign m_ready = m_ready_q;
  assign level   = level_q;

  always_comb begin
    level_next = level_q;
    if (push && !pop) begin
      level_next = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      m_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {m_last, m_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level_q   <= level_next;
      // Looks at next level so a pop from full reopens m_ready one cycle later.
      m_ready_q <= (level_next != LVL_W'(DEPTH));
    end
  end

`ifdef SKID_FIFO_PKTCNT_EN
  logic [LVL_W-1:0] pkt_q;
  logic             pkt_in;
  logic             pkt_out;

  assign pkt_in  = push & m_last;
  assign pkt_out = pop & s_last;
  assign pkt_cnt = pkt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q <= '0;
    end else if (pkt_in && !pkt_out) begin
      pkt_q <= pkt_q + LVL_W'(1);
    end else if (pkt_out && !pkt_in) begin
      pkt_q <= pkt_q - LVL_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_skid_fifo_axis.sv
// Bench for skid_fifo_axis (DATA_W=8, DEPTH=4): directed steps plus random traffic against a queue model.
// Define SKID_FIFO_PKTCNT_EN for both files to also check pkt_cnt.
module tb_skid_fifo_axis;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_valid = 1'b0;
  logic              m_last = 1'b0;
  logic              m_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready = 1'b0;
  logic [LVL_W-1:0]  level;
`ifdef SKID_FIFO_PKTCNT_EN
  logic [LVL_W-1:0]  pkt_cnt;
`endif

  always #5 clk = ~clk;

  skid_fifo_axis #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
`ifdef SKID_FIFO_PKTCNT_EN
    .level   (level),
    .pkt_cnt (pkt_cnt)
`else
    .level   (level)
`endif
  );

  // Reference: queue of {last,data} words, plus the registered ready flag.
  logic [DATA_W:0] model_q [$];
  logic            model_rdy = 1'b0;
  bit              accepted;
  int              total = 0;
  int              bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pkts();
    int n = 0;
    foreach (model_q[i]) if (model_q[i][DATA_W]) n++;
    return n;
  endfunction

  task automatic check_all(input string tag);
    logic [DATA_W:0] hd;
    hd = (model_q.size() != 0) ? model_q[0] : '0;
    chk({tag, "_s_valid"}, 32'(s_valid), 32'(model_q.size() != 0));
    chk({tag, "_s_data"},  32'(s_data),  32'(hd[DATA_W-1:0]));
    chk({tag, "_s_last"},  32'(s_last),  32'(hd[DATA_W]));
    chk({tag, "_level"},   32'(level),   32'(model_q.size()));
    chk({tag, "_m_ready"}, 32'(m_ready), 32'(model_rdy));
`ifdef SKID_FIFO_PKTCNT_EN
    chk({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(model_pkts()));
`endif
  endtask

  task automatic tick(input string tag);
    bit do_push, do_pop;
    logic [DATA_W:0] word;
    do_push = m_valid && model_rdy;
    do_pop  = (model_q.size() != 0) && s_ready;
    word    = {m_last, m_data};
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(word);
    model_rdy = (model_q.size() != DEPTH);
    accepted  = do_push;
    #1;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    m_valid = 1'b0;
    s_ready = 1'b1;
    for (int i = 0; i < 10 && model_q.size() != 0; i++) tick(tag);
    chk({tag, "_empty"}, 32'(level), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] stream_v [4];
    logic [DATA_W-1:0] fill_v [5];
    logic [DATA_W-1:0] got [$];
    int idx;
    bit done;
    stream_v = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill_v   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    // Reset with upstream offering FF: nothing stored, all outputs low.
    m_valid = 1'b1;
    m_data  = 8'hFF;
    #12;
    check_all("reset");
    #6;
    reset   = 1'b1;
    m_valid = 1'b0;
    tick("rst_release");
    chk("rst_release_rdy", 32'(m_ready), 32'd1);

    // Streaming with an always-ready sink.
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_valid = 1'b1;
      m_data  = stream_v[i];
      m_last  = (i == 3);
      tick("stream");
      chk("stream_data", 32'(s_data), 32'(stream_v[i]));
      chk("stream_lvl_le1", 32'(level <= 1), 32'd1);
      chk("stream_rdy", 32'(m_ready), 32'd1);
    end
    m_valid = 1'b0;
    m_last  = 1'b0;
    tick("stream_tail");

    // Fill to full; the fifth word must be held upstream.
    s_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      m_valid = 1'b1;
      m_data  = fill_v[idx];
      m_last  = (idx == 4);
      tick("fill");
      if (accepted) idx++;
    end
    chk("fill_accepted", 32'(idx), 32'd4);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_rdy", 32'(m_ready), 32'd0);
    s_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (s_valid && s_ready) got.push_back(s_data);
      if (idx < 5) begin
        m_valid = 1'b1;
        m_data  = fill_v[idx];
        m_last  = (idx == 4);
      end else begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
      tick("fill_drain");
      if (accepted) idx++;
      done = (idx == 5) && (level == 0);
    end
    chk("fill_drain_done", 32'(done), 32'd1);
    chk("fill_order_n", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("fill_order", 32'(got[i]), 32'(fill_v[i]));

    // Stall stability with head CC, then exactly one pop.
    s_ready = 1'b0;
    m_valid = 1'b1;
    m_data  = 8'hCC;
    tick("stall_push");
    m_data  = 8'hDD;
    tick("stall_push");
    m_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick("stall_hold");
      chk("stall_data", 32'(s_data), 32'hCC);
      chk("stall_valid", 32'(s_valid), 32'd1);
    end
    s_ready = 1'b1;
    tick("stall_pop");
    chk("stall_no_dup", 32'(s_data), 32'hDD);
    drain("stall_drain");

    // Concurrent push/pop at level 2 across pointer wrap.
    s_ready = 1'b0;
    m_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_data = 8'($urandom);
      tick("conc_prefill");
    end
    s_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m_data = 8'($urandom);
      m_last = 1'($urandom);
      tick("concurrent");
      chk("conc_level", 32'(level), 32'd2);
    end
    m_last = 1'b0;
    drain("conc_drain");

    // Random traffic, alternating sink-heavy and source-heavy phases.
    for (int i = 0; i < 400; i++) begin
      m_valid = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      s_ready = ((i / 50) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      m_data  = 8'($urandom);
      m_last  = ($urandom_range(0, 3) == 0);
      tick("random");
    end
    m_last = 1'b0;
    drain("random_drain");

    // Reset mid-packet: three words stored, one complete packet.
    s_ready = 1'b0;
    m_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_data = 8'h60 + 8'(i);
      m_last = (i == 1);
      tick("mid_fill");
    end
    m_valid = 1'b0;
    m_last  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_q.delete();
    model_rdy = 1'b0;
    check_all("mid_reset");
    #4;
    reset   = 1'b1;
    s_ready = 1'b1;
    m_valid = 1'b1;
    m_data  = 8'h5A;
    m_last  = 1'b1;
    tick("post_rst_rdy");
    chk("post_rst_rdy_hi", 32'(m_ready), 32'd1);
    tick("post_rst_push");
    chk("post_rst_new", 32'(s_data), 32'h5A);
    m_valid = 1'b0;
    m_last  = 1'b0;
    for (int i = 0; i < 4; i++) tick("post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
